// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load opcodes,
// load-response states and the execute-to-memory bus layout.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 74;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_TO_DS_BUS_WD = 39;

    localparam logic [2:0] LOAD_OP_W  = 3'b000;
    localparam logic [2:0] LOAD_OP_B  = 3'b001;
    localparam logic [2:0] LOAD_OP_H  = 3'b010;
    localparam logic [2:0] LOAD_OP_BU = 3'b011;
    localparam logic [2:0] LOAD_OP_HU = 3'b100;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HELD  = 2'd2
    } ld_state_e;

    typedef struct packed {
        logic [2:0]  load_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/half of the returned
// word and sign- or zero-extends it according to the load opcode.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = lane[addr];
    assign sel_half = addr[1] ? word[31:16] : word[15:0];

    // Unused opcodes fall through to a full-word load.
    always_comb begin
        result = word;
        case (load_op)
            LOAD_OP_B:  result = {{24{sel_byte[7]}}, sel_byte};
            LOAD_OP_BU: result = {24'd0, sel_byte};
            LOAD_OP_H:  result = {{16{sel_half[15]}}, sel_half};
            LOAD_OP_HU: result = {16'd0, sel_half};
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute bus, waits for the data
// SRAM response on loads, aligns load data and feeds write-back and decode.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata
);

    es_to_ms_t in_bus;
    es_to_ms_t bus_q, bus_d;
    logic      ms_valid_q, ms_valid_d;
    ld_state_e state_q, state_d;
    logic [31:0] hold_q, hold_d;

    logic        data_ok_wait;
    logic        data_ok_seen;
    logic        ms_ready_go;
    logic        accept;
    logic        accept_load;
    logic [31:0] load_word;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign in_bus = es_to_ms_t'(es_to_ms_bus);

    // A response only counts while a load is actually outstanding, so a stale
    // data_ok left over from before a reset cannot release anything.
    assign data_ok_wait = (state_q == ST_WAIT) && data_sram_data_ok;
    assign data_ok_seen = (state_q == ST_HELD) || data_ok_wait;

    assign ms_ready_go    = !ms_valid_q || !bus_q.res_from_mem || data_ok_seen;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

    assign accept      = es_to_ms_valid && ms_allowin;
    assign accept_load = accept && in_bus.res_from_mem;

    always_comb begin
        ms_valid_d = ms_valid_q;
        bus_d      = bus_q;
        state_d    = state_q;
        hold_d     = hold_q;

        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (accept) begin
            bus_d = in_bus;
        end

        case (state_q)
            ST_EMPTY: begin
                if (accept_load) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_sram_data_ok) begin
                    if (ws_allowin) begin
                        state_d = accept_load ? ST_WAIT : ST_EMPTY;
                    end else begin
                        state_d = ST_HELD;
                        hold_d  = data_sram_rdata;
                    end
                end
            end
            ST_HELD: begin
                if (ws_allowin) begin
                    state_d = accept_load ? ST_WAIT : ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
            bus_q      <= '0;
            state_q    <= ST_EMPTY;
            hold_q     <= 32'd0;
        end else begin
            ms_valid_q <= ms_valid_d;
            bus_q      <= bus_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
        end
    end

    assign load_word = (state_q == ST_HELD) ? hold_q : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .load_op (bus_q.load_op),
        .addr    (bus_q.alu_result[1:0]),
        .word    (load_word),
        .result  (load_result)
    );

    assign final_result = bus_q.res_from_mem ? load_result : bus_q.alu_result;

    assign ms_to_ws_bus = {bus_q.gr_we, bus_q.dest, final_result, bus_q.pc};

    assign ms_to_ds_bus = {ms_valid_q && bus_q.gr_we,
                           ms_valid_q && bus_q.res_from_mem && !data_ok_seen,
                           bus_q.dest,
                           final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-back words are queued when an
// instruction is driven and compared as the stage hands them to write-back.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_to_ds_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_bus      (ms_to_ds_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [69:0] exp_q [$];
    logic [69:0] mon_exp;

    // Data-SRAM responder state: one outstanding load at a time.
    logic        cap_req  = 1'b0;
    int          cap_lat  = 0;
    logic [31:0] cap_data = 32'd0;
    logic        pend     = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'd0;

    task automatic check(input string tag, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [73:0] mk_es(input logic [2:0] op, input logic rfm, input logic we,
                                          input logic [4:0] dest, input logic [31:0] alu,
                                          input logic [31:0] pc);
        return {op, rfm, we, dest, alu, pc};
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the capturing edge.
    task automatic send(input logic [73:0] bus, input logic expect_wb, input logic [31:0] exp_res,
                        input logic [31:0] rdata, input int lat, output int waits);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        waits          = 0;
        if (expect_wb) begin
            exp_q.push_back({bus[69], bus[68:64], exp_res, bus[31:0]});
        end
        @(negedge clk);
        while (!ms_allowin && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!ms_allowin) begin
            check("accept_timeout", 70'(ms_allowin), 70'd1);
        end else if (bus[70]) begin
            cap_req  = 1'b1;
            cap_lat  = lat;
            cap_data = rdata;
        end
        $display("send pc=%h op=%0d load=%0d alu=%h waits=%0d", bus[31:0], bus[73:71], bus[70],
                 bus[63:32], waits);
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'hDEAD_BEEF;
            if (pend) begin
                if (pend_cnt == 0) begin
                    data_sram_data_ok = 1'b1;
                    data_sram_rdata   = pend_data;
                    pend              = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (cap_req) begin
                cap_req = 1'b0;
                if (cap_lat == 0) begin
                    data_sram_data_ok = 1'b1;
                    data_sram_rdata   = cap_data;
                end else begin
                    pend      = 1'b1;
                    pend_cnt  = cap_lat - 1;
                    pend_data = cap_data;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 70'(ms_to_ws_valid), 70'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("wb_bus", ms_to_ws_bus, mon_exp);
                $display("wb   pc=%h dest=%0d we=%0d result=%h", ms_to_ws_bus[31:0],
                         ms_to_ws_bus[68:64], ms_to_ws_bus[69], ms_to_ws_bus[63:32]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [69:0] exp_held;

        reset             = 1'b1;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_allowin", 70'(ms_allowin), 70'd1);
        check("rst_ws_valid", 70'(ms_to_ws_valid), 70'd0);
        check("rst_ds_bus", 70'(ms_to_ds_bus), 70'd0);
        check("rst_ws_bus", ms_to_ws_bus, 70'd0);
        sync();
        reset = 1'b0;
        sync();

        // Non-load passes through in one cycle.
        send(mk_es(LOAD_OP_W, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000), 1'b1,
             32'h1234_5678, 32'd0, 0, w);
        @(negedge clk);
        check("nl_valid", 70'(ms_to_ws_valid), 70'd1);
        check("nl_fwd", 70'(ms_to_ds_bus), 70'({1'b1, 1'b0, 5'd5, 32'h1234_5678}));
        sync();

        // LD_B at byte 2 with one stall cycle.
        send(mk_es(LOAD_OP_B, 1'b1, 1'b1, 5'd6, 32'h0000_1002, 32'h1C00_0004), 1'b1,
             32'hFFFF_FF80, 32'h0080_0000, 1, w);
        @(negedge clk);
        check("ldb_pending", 70'(ms_to_ds_bus[38:37]), 70'd3);
        check("ldb_stall", 70'(ms_to_ws_valid), 70'd0);
        sync();

        send(mk_es(LOAD_OP_HU, 1'b1, 1'b1, 5'd7, 32'h0000_2002, 32'h1C00_0008), 1'b1,
             32'h0000_8001, 32'h8001_0000, 1, w);
        send(mk_es(LOAD_OP_H, 1'b1, 1'b1, 5'd8, 32'h0000_2002, 32'h1C00_000C), 1'b1,
             32'hFFFF_8001, 32'h8001_0000, 1, w);
        send(mk_es(LOAD_OP_BU, 1'b1, 1'b0, 5'd9, 32'h0000_3003, 32'h1C00_0010), 1'b1,
             32'h0000_009A, 32'h9A00_0000, 0, w);
        repeat (3) sync();

        // Response arrives while write-back is blocked: word must be held.
        send(mk_es(LOAD_OP_W, 1'b1, 1'b1, 5'd10, 32'h0000_2000, 32'h1C00_0014), 1'b1,
             32'hCAFE_F00D, 32'hCAFE_F00D, 1, w);
        ws_allowin = 1'b0;
        exp_held   = {1'b1, 5'd10, 32'hCAFE_F00D, 32'h1C00_0014};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held_allowin", 70'(ms_allowin), 70'd0);
            check("held_valid", 70'(ms_to_ws_valid), 70'd1);
            check("held_bus", ms_to_ws_bus, exp_held);
        end
        sync();
        ws_allowin = 1'b1;
        send(mk_es(LOAD_OP_W, 1'b0, 1'b1, 5'd11, 32'h0000_0055, 32'h1C00_0018), 1'b1,
             32'h0000_0055, 32'd0, 0, w);
        check("held_entry_waits", 70'(w), 70'd0);
        repeat (2) sync();

        // Back-to-back loads with two-cycle latency.
        send(mk_es(LOAD_OP_W, 1'b1, 1'b1, 5'd12, 32'h0000_4000, 32'h1C00_001C), 1'b1,
             32'h1111_2222, 32'h1111_2222, 2, w);
        send(mk_es(LOAD_OP_B, 1'b1, 1'b1, 5'd13, 32'h0000_4001, 32'h1C00_0020), 1'b1,
             32'hFFFF_FFF3, 32'h0000_F300, 2, w);
        check("b2b_waits", 70'(w), 70'd2);
        repeat (5) sync();

        // Reset while a load is outstanding; its late response must be ignored.
        send(mk_es(LOAD_OP_W, 1'b1, 1'b1, 5'd14, 32'h0000_5000, 32'h1C00_0024), 1'b0,
             32'd0, 32'h7777_7777, 3, w);
        reset = 1'b1;
        sync();
        sync();
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 70'(ms_to_ws_valid), 70'd0);
        check("rst_mid_allowin", 70'(ms_allowin), 70'd1);
        @(negedge clk);
        check("stale_ok_valid", 70'(ms_to_ws_valid), 70'd0);
        check("stale_ok_allowin", 70'(ms_allowin), 70'd1);
        check("stale_ok_pending", 70'(ms_to_ds_bus[37]), 70'd0);
        sync();

        // Unused opcode behaves as a full-word load.
        send(mk_es(3'b101, 1'b1, 1'b1, 5'd15, 32'h0000_6002, 32'h1C00_0028), 1'b1,
             32'h8765_4321, 32'h8765_4321, 1, w);
        repeat (6) sync();

        check("sb_empty", 70'(exp_q.size()), 70'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage in-order LoongArch pipeline, between the execute stage and the write-back stage.
- Latches the execute-to-memory bus under a valid/allowin handshake and waits for the data-SRAM response on loads.
- Aligns and extends load data, then drives the 70-bit memory-to-writeback bus (reg_we, dest, final_result, pc).
- Also drives a forwarding/hazard bus back to decode.

Parameters:
- ES_TO_MS_BUS_WD, 74, width of the execute-to-memory bus.
- MS_TO_WS_BUS_WD, 70, width of the memory-to-writeback bus.
- MS_TO_DS_BUS_WD, 39, width of the forwarding bus.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ws_allowin  in  1  write-back stage can accept.
- ms_allowin  out  1  this stage can accept.
- es_to_ms_valid  in  1  execute stage offers an instruction.
- es_to_ms_bus  in  74  {load_op[2:0], res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}.
- ms_to_ws_valid  out  1  instruction ready for write-back.
- ms_to_ws_bus  out  70  {gr_we, dest[4:0], final_result[31:0], pc[31:0]}.
- ms_to_ds_bus  out  39  {fwd_we, load_pending, dest[4:0], final_result[31:0]}.
- data_sram_data_ok  in  1  load data returned this cycle.
- data_sram_rdata  in  32  returned load word.

Behaviour:
- Handshake:
  - ms_ready_go = !ms_valid || !res_from_mem || data_ok_seen, where data_ok_seen = (state==HELD) || data_sram_data_ok.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Capture:
  - When ms_allowin: ms_valid <= es_to_ms_valid.
  - When es_to_ms_valid && ms_allowin: bus register <= es_to_ms_bus.
- Load-response FSM (2 bits):
  - EMPTY: nothing outstanding. On accepting an instruction with res_from_mem=1, go to WAIT.
  - WAIT: load outstanding.
    - data_ok && ws_allowin: go to EMPTY, or back to WAIT if a new load is accepted the same cycle.
    - data_ok && !ws_allowin: go to HELD and latch rdata into the hold register.
  - HELD: data buffered. When ws_allowin, go to EMPTY, or WAIT if a new load is accepted.
  - Load word source: data_sram_rdata in WAIT, hold register in HELD.
- data_ok outside WAIT (a stale response, e.g. after reset): ignored, no state change.
- Load alignment by alu_result[1:0]:
  - 000 LD_W: full word.
  - 001 LD_B: byte at addr[1:0], sign-extended.
  - 011 LD_BU: byte at addr[1:0], zero-extended.
  - 010 LD_H: half selected by addr[1] (0 = bits 15:0, 1 = bits 31:16), sign-extended.
  - 100 LD_HU: same half selection, zero-extended.
  - Codes 101–111 behave as LD_W.
  - Misalignment is not checked here.
- final_result = res_from_mem ? aligned load : alu_result.
- Forwarding bus:
  - fwd_we = ms_valid && gr_we.
  - load_pending = ms_valid && res_from_mem && !data_ok_seen (decode must stall on a match).
  - dest and final_result are passed through.
- Reset values:
  - ms_valid = 0, state = EMPTY, hold register = 0, bus register = 0.
  - Therefore ms_to_ws_valid = 0, fwd_we = 0, load_pending = 0, ms_allowin = 1.
- Reset mid-operation: reset wins over all other events. An outstanding load is abandoned and its late data_ok is ignored.
- Latency: a non-load passes through in 1 cycle. A load stays until data_ok; the earliest exit is the same cycle data_ok arrives, via the combinational path from rdata to ms_to_ws_bus.

Decomposition:
- Shared header mycpu.h holds:
  - ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, MS_TO_DS_BUS_WD.
  - LOAD_OP_W/B/H/BU/HU encodings.
  - FSM state encodings.
- One natural sub-module: load_align (combinational: load_op, addr[1:0], word → 32-bit result).

Test Plan:
- Non-load: alu_result=0x1234_5678, gr_we=1, dest=5, pc=0x1C00_0000 → next cycle ms_to_ws_bus={1,5,0x12345678,0x1C000000}, valid=1.
- LD_B at addr[1:0]=2, rdata=0x0080_0000, data_ok one cycle after capture → stalls one cycle with load_pending=1, then final_result=0xFFFF_FF80.
- LD_HU at addr[1]=1, rdata=0x8001_0000 → final_result=0x0000_8001. LD_H at the same address → 0xFFFF_8001.
- data_ok while ws_allowin=0 for 3 cycles → state HELD, ms_allowin=0, bus stable. When ws_allowin returns, the held word is written back and the next instruction enters the same cycle.
- Back-to-back loads, each with 2-cycle latency → both complete in order with no dropped or duplicated ms_to_ws_valid.
- Reset asserted in WAIT, data_ok arrives the cycle after reset drops → state EMPTY, ms_to_ws_valid stays 0.
